// File: rtl/udp_reg_ring_master.sv
// Register-ring initiator: one core request -> one tagged ring transaction; foreign traffic forwarded with 1-cycle latency.
// UDP_REG_MASTER_TIMEOUT_EN builds the WAIT timeout counter; without it WAIT blocks until the own return arrives.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 1023
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 core_reg_req,
  input  logic                                 core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]       core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]      core_reg_wr_data,
  output logic                                 core_reg_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]      core_reg_rd_data,
  output logic                                 core_reg_err,
  input  logic                                 reg_req_in,
  input  logic                                 reg_ack_in,
  input  logic                                 reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_in,
  output logic                                 reg_req_out,
  output logic                                 reg_ack_out,
  output logic                                 reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]       reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]      reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]         reg_src_out
);
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [UDP_REG_SRC_WIDTH-1:0] OWN_SRC = UDP_REG_SRC_WIDTH'(SRC_ID);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                         state_q, state_d;
  logic                           rd_wr_L_q, rd_wr_L_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [DW-1:0]                  wdata_q, wdata_d;
  logic                           req_out_q, req_out_d, ack_out_q, ack_out_d, rdwr_out_q, rdwr_out_d;
  logic [AW-1:0]                  addr_out_q, addr_out_d;
  logic [DW-1:0]                  data_out_q, data_out_d;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_out_q, src_out_d;
  logic                           core_ack_q, core_ack_d, core_err_q, core_err_d;
  logic [DW-1:0]                  core_rd_q, core_rd_d;

  logic foreign, own, timeout_hit;
  assign foreign = reg_req_in && (reg_src_in != OWN_SRC);
  assign own     = reg_req_in && (reg_src_in == OWN_SRC);

`ifdef UDP_REG_MASTER_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;
  assign timeout_hit = (state_q == WAIT) && (cnt_q == 10'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE && !foreign) cnt_d = '0;
    else if (state_q == WAIT && !timeout_hit) cnt_d = cnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Constant-false: a negative TIMEOUT can never arm, so WAIT only leaves on the own return.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d    = state_q;
    rd_wr_L_d  = rd_wr_L_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_out_d  = 1'b0;
    ack_out_d  = 1'b0;
    rdwr_out_d = 1'b0;
    addr_out_d = '0;
    data_out_d = '0;
    src_out_d  = '0;
    core_ack_d = 1'b0;
    core_rd_d  = '0;
    core_err_d = 1'b0;

    // Foreign traffic always owns the output slot; own-tagged input is never forwarded.
    if (foreign) begin
      req_out_d  = 1'b1;
      ack_out_d  = reg_ack_in;
      rdwr_out_d = reg_rd_wr_L_in;
      addr_out_d = reg_addr_in;
      data_out_d = reg_data_in;
      src_out_d  = reg_src_in;
    end

    case (state_q)
      IDLE: begin
        if (core_reg_req) begin
          rd_wr_L_d = core_reg_rd_wr_L;
          addr_d    = core_reg_addr;
          wdata_d   = core_reg_wr_data;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!foreign) begin
          req_out_d  = 1'b1;
          src_out_d  = OWN_SRC;
          rdwr_out_d = rd_wr_L_q;
          addr_out_d = addr_q;
          data_out_d = rd_wr_L_q ? '0 : wdata_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (own) begin
          core_ack_d = 1'b1;
          core_rd_d  = reg_ack_in ? reg_data_in : DW'(32'hDEAD_BEEF);
          core_err_d = !reg_ack_in;
          state_d    = DONE;
        end else if (timeout_hit) begin
          core_ack_d = 1'b1;
          core_rd_d  = DW'(32'hDEAD_0000);
          core_err_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_wr_L_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_out_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      rdwr_out_q <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      src_out_q  <= '0;
      core_ack_q <= 1'b0;
      core_rd_q  <= '0;
      core_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_wr_L_q  <= rd_wr_L_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_out_q  <= req_out_d;
      ack_out_q  <= ack_out_d;
      rdwr_out_q <= rdwr_out_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      src_out_q  <= src_out_d;
      core_ack_q <= core_ack_d;
      core_rd_q  <= core_rd_d;
      core_err_q <= core_err_d;
    end
  end

  assign reg_req_out      = req_out_q;
  assign reg_ack_out      = ack_out_q;
  assign reg_rd_wr_L_out  = rdwr_out_q;
  assign reg_addr_out     = addr_out_q;
  assign reg_data_out     = data_out_q;
  assign reg_src_out      = src_out_q;
  assign core_reg_ack     = core_ack_q;
  assign core_reg_rd_data = core_rd_q;
  assign core_reg_err     = core_err_q;

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Directed bench for udp_reg_ring_master: read/write loopback, foreign priority, timeout, reset, back-to-back.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_reg_req, core_reg_rd_wr_L;
  logic [AW-1:0] core_reg_addr;
  logic [DW-1:0] core_reg_wr_data;
  logic          core_reg_ack, core_reg_err;
  logic [DW-1:0] core_reg_rd_data;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;

  int n_tests = 0;
  int n_fail  = 0;

  udp_reg_ring_master #(.UDP_REG_SRC_WIDTH(SW), .SRC_ID(0), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_ack(core_reg_ack), .core_reg_rd_data(core_reg_rd_data), .core_reg_err(core_reg_err),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed hang, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; DUT outputs are then sampled #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_idle();
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  task automatic ring_drive(input logic ack, input logic rdwr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    reg_req_in = 1'b1; reg_ack_in = ack; reg_rd_wr_L_in = rdwr;
    reg_addr_in = a; reg_data_in = d; reg_src_in = s;
  endtask

  task automatic core_drive(input logic req, input logic rdwr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_reg_req = req; core_reg_rd_wr_L = rdwr; core_reg_addr = a; core_reg_wr_data = d;
  endtask

  initial begin
    int iss_cyc[2];
    int n_iss, n_ack, got;
    logic [DW-1:0] ack_dat[2];

    reset = 1'b1;
    core_drive(1'b0, 1'b0, '0, '0);
    ring_idle();
    step(); step();
    chk("rst_req_out", 64'(reg_req_out), 64'd0);
    chk("rst_data_out", 64'(reg_data_out), 64'd0);
    chk("rst_src_addr", 64'({reg_src_out, reg_addr_out, reg_ack_out, reg_rd_wr_L_out}), 64'd0);
    chk("rst_core", 64'({core_reg_ack, core_reg_err, core_reg_rd_data}), 64'd0);
    reset = 1'b0;
    step();

    // Read loopback with ack
    core_drive(1'b1, 1'b1, AW'(24'h000010), '0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    chk("rd_no_issue_yet", 64'(reg_req_out), 64'd0);
    step();
    chk("rd_issue_req", 64'(reg_req_out), 64'd1);
    chk("rd_issue_fields", 64'({reg_ack_out, reg_rd_wr_L_out, reg_src_out}), 64'({1'b0, 1'b1, 2'd0}));
    chk("rd_issue_addr", 64'(reg_addr_out), 64'h10);
    chk("rd_issue_data", 64'(reg_data_out), 64'd0);
    ring_drive(1'b1, 1'b1, AW'(24'h000010), 32'h1234_5678, 2'd0);
    step();
    ring_idle();
    chk("rd_ack", 64'(core_reg_ack), 64'd1);
    chk("rd_data", 64'(core_reg_rd_data), 64'h1234_5678);
    chk("rd_err", 64'(core_reg_err), 64'd0);
    chk("rd_return_not_fwd", 64'(reg_req_out), 64'd0);
    step();
    chk("rd_ack_one_cycle", 64'(core_reg_ack), 64'd0);

    // Write, unclaimed return
    core_drive(1'b1, 1'b0, AW'(24'h000020), 32'hA5A5_A5A5);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    step();
    chk("wr_issue_req", 64'(reg_req_out), 64'd1);
    chk("wr_issue_data", 64'(reg_data_out), 64'hA5A5_A5A5);
    chk("wr_issue_rdwr", 64'(reg_rd_wr_L_out), 64'd0);
    ring_drive(1'b0, 1'b0, AW'(24'h000020), 32'hA5A5_A5A5, 2'd0);
    step();
    ring_idle();
    chk("wr_ack", 64'(core_reg_ack), 64'd1);
    chk("wr_unclaimed_data", 64'(core_reg_rd_data), 64'hDEAD_BEEF);
    chk("wr_unclaimed_err", 64'(core_reg_err), 64'd1);
    step();

    // Foreign transaction collides with ISSUE
    core_drive(1'b1, 1'b1, AW'(24'h000030), '0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    ring_drive(1'b1, 1'b0, AW'(24'h7ABCDE), 32'hCAFE_F00D, 2'd1);
    step();
    ring_idle();
    chk("fw_req", 64'(reg_req_out), 64'd1);
    chk("fw_ctl", 64'({reg_ack_out, reg_rd_wr_L_out, reg_src_out}), 64'({1'b1, 1'b0, 2'd1}));
    chk("fw_addr", 64'(reg_addr_out), 64'h7ABCDE);
    chk("fw_data", 64'(reg_data_out), 64'hCAFE_F00D);
    step();
    chk("fw_own_after_req", 64'(reg_req_out), 64'd1);
    chk("fw_own_after_src", 64'(reg_src_out), 64'd0);
    chk("fw_own_after_addr", 64'(reg_addr_out), 64'h30);
    ring_drive(1'b1, 1'b1, AW'(24'h000030), 32'h0000_0055, 2'd0);
    step();
    ring_idle();
    chk("fw_own_ack_data", 64'({core_reg_ack, core_reg_err, core_reg_rd_data}), 64'({1'b1, 1'b0, 32'h55}));
    step();

`ifdef UDP_REG_MASTER_TIMEOUT_EN
    // Timeout with TIMEOUT=8, then a late own return is dropped
    core_drive(1'b1, 1'b0, AW'(24'h000040), 32'h1);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    step();
    chk("to_issue", 64'(reg_req_out), 64'd1);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (core_reg_ack) begin got = k; break; end
    end
    chk("to_latency", 64'(got), 64'd9);
    chk("to_data", 64'(core_reg_rd_data), 64'hDEAD_0000);
    chk("to_err", 64'(core_reg_err), 64'd1);
    step();
    ring_drive(1'b1, 1'b0, AW'(24'h000040), 32'h1, 2'd0);
    step();
    ring_idle();
    chk("to_late_drop", 64'({reg_req_out, reg_data_out, reg_addr_out}), 64'd0);
    chk("to_late_no_ack", 64'(core_reg_ack), 64'd0);
`endif

    // Reset during WAIT
    core_drive(1'b1, 1'b1, AW'(24'h000050), '0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    step();
    chk("rw_issue", 64'(reg_req_out), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_ring_zero", 64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out, reg_addr_out}), 64'd0);
    chk("rw_core_zero", 64'({core_reg_ack, core_reg_err, core_reg_rd_data}), 64'd0);
    ring_drive(1'b1, 1'b1, AW'(24'h000050), 32'h0000_0099, 2'd0);
    step();
    ring_idle();
    chk("rw_stray_drop", 64'({reg_req_out, reg_data_out}), 64'd0);
    chk("rw_stray_no_ack", 64'(core_reg_ack), 64'd0);
    core_drive(1'b1, 1'b1, AW'(24'h000060), '0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    step();
    chk("rw_new_issue", 64'({reg_req_out, reg_addr_out}), 64'({1'b1, AW'(24'h000060)}));
    ring_drive(1'b1, 1'b1, AW'(24'h000060), 32'h0000_0077, 2'd0);
    step();
    ring_idle();
    chk("rw_new_done", 64'({core_reg_ack, core_reg_err, core_reg_rd_data}), 64'({1'b1, 1'b0, 32'h77}));
    step();

    // Back-to-back with core_reg_req held high; ring loops own issues back next cycle
    n_iss = 0; n_ack = 0;
    iss_cyc[0] = 0; iss_cyc[1] = 0; ack_dat[0] = '0; ack_dat[1] = '0;
    core_drive(1'b1, 1'b1, AW'(24'h000070), '0);
    for (int c = 1; c <= 16; c++) begin
      step();
      ring_idle();
      if (core_reg_ack) begin
        if (n_ack < 2) ack_dat[n_ack] = core_reg_rd_data;
        n_ack++;
        if (n_ack == 2) core_reg_req = 1'b0;
      end
      if (reg_req_out && reg_src_out == 2'd0) begin
        if (n_iss < 2) iss_cyc[n_iss] = c;
        ring_drive(1'b1, 1'b1, AW'(24'h000070), DW'(32'hB000 + n_iss), 2'd0);
        n_iss++;
      end
    end
    ring_idle();
    chk("b2b_issues", 64'(n_iss), 64'd2);
    chk("b2b_acks", 64'(n_ack), 64'd2);
    chk("b2b_gap", 64'(iss_cyc[1] - iss_cyc[0]), 64'd4);
    chk("b2b_ack0", 64'(ack_dat[0]), 64'hB000);
    chk("b2b_ack1", 64'(ack_dat[1]), 64'hB001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
